i2s_dac_tx: RTL and testbench



---
 rtl/i2s_dac_tx.sv | 100 ++++++++++
 tb/tb_i2s_dac_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S transmitter serialising held stereo samples, silent frame on underrun
module i2s_dac_tx #(
   parameter int DATA_W   = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] audioInL,
   input  logic [DATA_W-1:0] audioInR,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              frame_start,
   output logic              underrun
);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int SW = $clog2(2 * DATA_W);
   localparam int FW = 2 * DATA_W;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t          r_state;
   logic [DW-1:0]   r_div;
   logic [SW-1:0]   r_slot;
   logic [FW-1:0]   r_hold;
   logic [FW-1:0]   r_shift;
   logic            r_lsb;
   logic            w_tc;
   logic            w_f;
   logic            w_wrap;
   logic            w_stop;
   logic            w_latch;
   logic            w_cap;
   assign w_tc    = r_div == DW'(BCLK_DIV - 1);
   assign w_f     = (r_state != IDLE) && w_tc && bclk;
   assign w_wrap  = w_f && (r_slot == SW'(FW - 1));
   assign w_stop  = w_wrap && (r_state == DRAIN) && !en;
   assign w_latch = ((r_state == IDLE) && en) || (w_wrap && !w_stop);
   assign w_cap   = in_valid && in_ready;
   // bit clock generation, slot sequencing, frame latch and producer handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_slot      <= '0;
         r_hold      <= '0;
         r_shift     <= '0;
         r_lsb       <= 1'b0;
         bclk        <= 1'b0;
         lrclk       <= 1'b0;
         sdata       <= 1'b0;
         in_ready    <= 1'b1;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= w_latch;
         underrun    <= w_latch && in_ready;
         if (w_cap) begin
            r_hold   <= {audioInL, audioInR};
            in_ready <= 1'b0;
         end else if (w_latch) begin
            in_ready <= 1'b1;
         end
         if (r_state == IDLE) begin
            r_div   <= '0;
            r_slot  <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
            r_state <= en ? RUN : IDLE;
         end else begin
            r_div <= w_tc ? '0 : r_div + DW'(1);
            if (w_tc) bclk <= ~bclk;
            if (w_stop) begin
               r_state <= IDLE;
               r_slot  <= '0;
               lrclk   <= 1'b0;
               sdata   <= 1'b0;
            end else begin
               r_state <= en ? RUN : DRAIN;
               if (w_f && !w_wrap) begin
                  r_slot  <= r_slot + SW'(1);
                  lrclk   <= r_slot >= SW'(DATA_W - 1);
                  sdata   <= r_shift[FW-1];
                  r_shift <= r_shift << 1;
               end
            end
         end
         // slot 0 carries the previous frame's right LSB, zero after a restart from IDLE
         if (w_latch) begin
            r_slot  <= '0;
            lrclk   <= 1'b0;
            sdata   <= (r_state == IDLE) ? 1'b0 : r_lsb;
            r_shift <= in_ready ? '0 : r_hold;
            r_lsb   <= in_ready ? 1'b0 : r_hold[0];
         end
      end
   end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed stimulus with a capture scoreboard and a bit-level frame monitor
module tb_i2s_dac_tx;
   localparam time FRAME_T = 2560;
   logic        clk = 1'b0;
   logic        reset, en, in_valid;
   logic [15:0] audioInL, audioInR;
   logic        in_ready, bclk, lrclk, sdata, frame_start, underrun;
   typedef struct {logic [31:0] d; time ts;} item_t;
   item_t       q[$];
   int          checks = 0, errors = 0;
   int          mon_slot = 0, fs_cnt = 0, ur_cnt = 0;
   logic        act = 1'b0, pb = 1'b0, exp_s0 = 1'b0, exp_ur;
   logic [31:0] cur = '0;
   time         last_fs = 0, gap = 0, last_rise = 0, t_latch;
   logic        have_fs = 1'b0;
   int          high_seen;

   i2s_dac_tx #(.DATA_W(16), .BCLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .en(en), .audioInL(audioInL), .audioInR(audioInR),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .lrclk(lrclk),
      .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // frame monitor: pops the scoreboard at each latch and checks every slot on bclk rise
   always @(negedge clk) begin
      if (reset) begin
         act = 1'b0; pb = 1'b0; have_fs = 1'b0; cur = '0;
      end else begin
         if (underrun && !frame_start) chk("underrun_alone", 32'(underrun), 32'd0);
         if (frame_start) begin
            t_latch = $time - 5;
            exp_ur = !(q.size() > 0 && q[0].ts < t_latch);
            chk("underrun", 32'(underrun), 32'(exp_ur));
            exp_s0 = (act && have_fs && (t_latch - last_fs == FRAME_T)) ? cur[0] : 1'b0;
            if (!exp_ur) begin
               cur = q.pop_front().d;
               chk("ready_rise", 32'(in_ready), 32'd1);
            end else cur = '0;
            if (have_fs) gap = t_latch - last_fs;
            last_fs = t_latch; have_fs = 1'b1;
            fs_cnt++;
            if (underrun) ur_cnt++;
            mon_slot = -1; act = 1'b1;
         end
         if (act && bclk && !pb) begin
            mon_slot++;
            if (mon_slot <= 31) begin
               chk($sformatf("lrclk_s%0d", mon_slot), 32'(lrclk), 32'(mon_slot >= 16));
               chk($sformatf("sdata_s%0d", mon_slot), 32'(sdata),
                   32'((mon_slot == 0) ? exp_s0 : cur[32-mon_slot]));
               if (mon_slot >= 1) chk("slot_len", 32'($time - last_rise), 32'd80);
            end
            last_rise = $time;
         end
         pb = bclk;
      end
   end

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      int n = 0;
      @(negedge clk);
      audioInL = l; audioInR = r; in_valid = 1'b1;
      while (!in_ready && n < 600) begin @(negedge clk); n++; end
      chk("send_wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      q.push_back('{d: {l, r}, ts: $time});
      @(negedge clk);
      chk("ready_drop", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_fs(input int lim);
      int k = 0;
      do begin @(negedge clk); k++; end while (!frame_start && k < lim);
      chk("fs_wait", 32'(frame_start), 32'd1);
      #1;
   endtask

   task automatic wait_slot(input int s);
      int k = 0;
      do begin @(negedge clk); #1; k++; end while (!(act && mon_slot == s) && k < 600);
      chk($sformatf("slot_wait_%0d", s), 32'(mon_slot), 32'(s));
   endtask

   initial begin
      int f0, u0;
      reset = 1'b1; en = 1'b0; in_valid = 1'b0; audioInL = '0; audioInR = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_outputs", 32'({bclk, lrclk, sdata, in_ready, frame_start, underrun}), 32'b000100);
      end
      send(16'hA5C3, 16'h8001);
      in_valid = 1'b0;
      en = 1'b1;
      @(negedge clk);
      chk("first_fs", 32'(frame_start), 32'd1);
      chk("first_ur", 32'(underrun), 32'd0);
      #1;
      wait_fs(300);
      f0 = fs_cnt; u0 = ur_cnt;
      repeat (770) @(negedge clk);
      #1;
      chk("fs_per_768", 32'(fs_cnt - f0), 32'd3);
      chk("ur_per_768", 32'(ur_cnt - u0), 32'd3);
      send(16'h1234, 16'hFEDC);
      send(16'h7FFF, 16'h8000);
      send(16'h0001, 16'hFFFF);
      send(16'h5A5A, 16'hC3C3);
      in_valid = 1'b0;
      repeat (600) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      wait_fs(300);
      wait_slot(10);
      en = 1'b0;
      f0 = fs_cnt;
      repeat (400) @(negedge clk);
      #1;
      chk("drain_last_slot", 32'(mon_slot), 32'd31);
      chk("drain_no_fs", 32'(fs_cnt - f0), 32'd0);
      high_seen = 0;
      repeat (20) begin @(negedge clk); high_seen += int'(bclk | lrclk | sdata); end
      chk("idle_quiet", 32'(high_seen), 32'd0);
      en = 1'b1;
      @(negedge clk);
      chk("restart_fs", 32'(frame_start), 32'd1);
      #1;
      wait_slot(5);
      en = 1'b0;
      wait_slot(20);
      en = 1'b1;
      wait_fs(300);
      chk("drain_resume_gap", 32'(gap), 32'(FRAME_T));
      wait_slot(31);
      repeat (3) @(negedge clk);
      audioInL = 16'hBEEF; audioInR = 16'h0F0F; in_valid = 1'b1;
      @(posedge clk);
      q.push_back('{d: {16'hBEEF, 16'h0F0F}, ts: $time});
      @(negedge clk);
      in_valid = 1'b0;
      chk("same_edge_fs", 32'(frame_start), 32'd1);
      chk("same_edge_ur", 32'(underrun), 32'd1);
      chk("same_edge_held", 32'(in_ready), 32'd0);
      #1;
      wait_fs(300);
      chk("same_edge_sent", 32'(q.size()), 32'd0);
      send(16'hCAFE, 16'hBABE);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 32'({bclk, lrclk, sdata, in_ready, frame_start, underrun}), 32'b000100);
      q.delete();
      en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      en = 1'b1;
      @(negedge clk);
      chk("post_reset_ur", 32'(underrun), 32'd1);
      repeat (300) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
